// File: rtl/phase_sequencer.sv
// phase_sequencer: parametrised multi-phase instruction sequencer.
// Generates one-hot phase enables with run/stop, single-step, stall hold,
// halt state, retired-instruction counter and a datapath reset chain.
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int PW         = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exec,
    input  logic                  step_mode,
    input  logic                  stall,
    input  logic                  halt,
    output logic [PW-1:0]         phase,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic                  running,
    output logic                  halted,
    output logic [CNT_W-1:0]      inst_count,
    output logic                  register_reset
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALT
    } state_t;

    localparam logic [PW-1:0]         LAST_PHASE = PW'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONE_HOT0   = NUM_PHASES'(1);

    state_t               state, state_nxt;
    logic [PW-1:0]        phase_nxt;
    logic [CNT_W-1:0]     count_nxt;
    logic                 stop_req, stop_req_nxt;
    logic                 exec_d;
    logic                 rr_q1, rr_q2;
    logic                 exec_event;

    // exec_d resets to 1 so a button held through reset is not an event
    assign exec_event     = exec & ~exec_d;
    assign register_reset = rr_q2;
    assign running        = (state == RUN) || (state == STEP);
    assign halted         = (state == HALT);

    // Exec edge-detect register and the two-flop datapath reset chain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exec_d <= 1'b1;
            rr_q1  <= 1'b1;
            rr_q2  <= 1'b1;
        end else begin
            exec_d <= exec;
            rr_q1  <= 1'b0;
            rr_q2  <= rr_q1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            inst_count <= '0;
            stop_req   <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            inst_count <= count_nxt;
            stop_req   <= stop_req_nxt;
        end
    end

    // Next-state, phase advance, completion handling and phase enables
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        count_nxt    = inst_count;
        stop_req_nxt = stop_req;
        phase_en     = '0;

        if (register_reset) begin
            state_nxt    = IDLE;
            phase_nxt    = '0;
            stop_req_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase_nxt = '0;
                    if (exec_event) begin
                        state_nxt = step_mode ? STEP : RUN;
                    end
                end
                RUN, STEP: begin
                    // a stop request latches even while stalled
                    if ((state == RUN) && exec_event) begin
                        stop_req_nxt = 1'b1;
                    end
                    if (!stall) begin
                        phase_en = ONE_HOT0 << phase;
                        if (phase == LAST_PHASE) begin
                            phase_nxt = '0;
                            count_nxt = inst_count + CNT_W'(1);
                            if (halt) begin
                                state_nxt    = HALT;
                                stop_req_nxt = 1'b0;
                            end else if (state == STEP) begin
                                state_nxt    = IDLE;
                                stop_req_nxt = 1'b0;
                            end else if (stop_req) begin
                                state_nxt    = IDLE;
                                stop_req_nxt = 1'b0;
                            end
                        end else begin
                            phase_nxt = phase + PW'(1);
                        end
                    end
                end
                HALT: begin
                    phase_nxt = '0;
                    if (exec_event) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    phase_nxt    = '0;
                    stop_req_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised multi-phase control sequencer for the 16-bit processor. It replaces the fixed 5-phase counter/control pair and generates the one-hot phase enables (p1..pN) that gate the PC, IR, register file, ALU and writeback stages. Over the fixed design it adds a configurable phase count, run/stop and single-step modes on the `exec` button, stall hold, a halt state and a retired-instruction counter.

## Interface
Parameters:
- `NUM_PHASES`, default 5: phases per instruction; legal range 2..16.
- `PW`, default 3: phase index width; must be at least $clog2(NUM_PHASES).
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `exec`  in  1  level input from the front-panel button, treated as a rising-edge event.
- `step_mode`  in  1  1 = each exec event runs exactly one instruction.
- `stall`  in  1  holds the current phase; suppresses all phase enables.
- `halt`  in  1  halt request from the decoder; sampled only when the last phase completes.
- `phase`  out  PW  current phase index, 0..NUM_PHASES-1.
- `phase_en`  out  NUM_PHASES  one-hot enable; bit i maps to p(i+1).
- `running`  out  1  high in RUN or STEP.
- `halted`  out  1  high in HALT.
- `inst_count`  out  CNT_W  number of completed instructions.
- `register_reset`  out  1  reset for datapath registers.

## Operation
- Edge detect: `exec_d` is the registered value of `exec` and resets to 1. An exec event is `exec & ~exec_d`. Holding exec high through reset therefore never starts the machine.
- States: IDLE, RUN, STEP, HALT. All are ignored while `register_reset` = 1 and the machine stays in IDLE.
- IDLE: phase = 0, phase_en = 0. An exec event moves to STEP if step_mode = 1, otherwise to RUN.
- RUN and STEP advance the phase:
  - phase_en = one-hot(phase) when stall = 0, otherwise all zeros.
  - At each edge with stall = 0, phase advances by one and wraps from NUM_PHASES-1 to 0.
  - With stall = 1, phase, state and count all hold.
- Completion is the edge where phase = NUM_PHASES-1 and stall = 0. At completion:
  - `inst_count` increments, wrapping at 2^CNT_W.
  - Next state is decided in this priority: halt = 1 goes to HALT; in STEP, go to IDLE; in RUN with `stop_req` set, go to IDLE; otherwise stay in RUN.
- Stop request: an exec event in RUN sets `stop_req`. The current instruction always finishes; the machine never stops mid-instruction. `stop_req` clears on entry to IDLE or HALT.
- Exec events during STEP are ignored.
- HALT: phase = 0, phase_en = 0, halted = 1. An exec event moves to IDLE, where halted = 0.
- register_reset is a 2-flop shift chain:
  - Both flops are set asynchronously by reset; each flop shifts in 0 on every edge.
  - The output is the second flop, so it is asserted asynchronously and deasserts after the 2nd rising edge following reset release.

## Timing
- Reset values: phase = 0, phase_en = 0, running = 0, halted = 0, inst_count = 0, register_reset = 1, state = IDLE, stop_req = 0, exec_d = 1.
- `phase_en` is combinational from the phase register, state and `stall`. All other outputs are registered.
- Start latency: an exec event sampled at edge k gives running = 1 and phase_en[0] = 1 in the cycle after edge k.
- Unstalled throughput: one instruction per NUM_PHASES cycles, with no bubble between instructions.
- `inst_count` and the state change are both visible after the completion edge.
- halt and stop_req together at completion: HALT wins.
- halt asserted in a non-final phase, or in the final phase while stall = 1, has no effect.
- reset asserted mid-instruction: all outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset release: reset 1→0 with exec held at 1 → register_reset falls after the 2nd edge; state stays IDLE; phase_en = 0.
- RUN with NUM_PHASES = 5: one exec pulse → phase_en cycles 00001, 00010, 00100, 01000, 10000 and repeats; inst_count = 3 after 15 cycles.
- Stop mid-instruction: an exec pulse at phase 2 → phases 3 and 4 complete, then IDLE; inst_count increments exactly once more.
- Step mode: step_mode = 1 with two exec pulses → exactly 2 instructions, running drops after each; an exec pulse mid-step is ignored.
- Stall and halt: stall = 1 for 3 cycles at phase 4 with halt = 1 → phase_en = 0 and no halt during the stall; at release → HALT, halted = 1; the next exec → IDLE.
- Async reset and parameters: reset pulse between edges at phase 3 → outputs zero immediately. Rerun the RUN test with NUM_PHASES = 3, PW = 2, CNT_W = 4 → one-hot over 3 bits; inst_count wraps 15 → 0.
